// File: rtl/karlsen_cutoff_coeff_gen.sv
// Pitch (octave.fraction) to prewarped ladder cutoff g ~= tan(pi*fc/fs) in Q1.15, plus resonance
// clamp. Define KARLSEN_COEFF_TAN_WARP_EN to add the x + x^3/3 tan prewarp stages.
module karlsen_cutoff_coeff_gen #(
    parameter int unsigned W     = 16,
    parameter int unsigned X0    = 43,
    parameter int unsigned THIRD = 10923
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                strobe,
    input  logic [W-1:0]        pitch,
    input  logic signed [W-1:0] resonance_in,
    output logic signed [W-1:0] g,
    output logic signed [W-1:0] resonance,
    output logic                g_valid
);

`ifdef KARLSEN_COEFF_TAN_WARP_EN
    typedef enum logic [3:0] {
        StIdle, StLut, StInterp, StScale, StShift, StSq, StCube, StThird, StSum
    } state_e;
`else
    typedef enum logic [3:0] {StIdle, StLut, StInterp, StScale, StShift} state_e;
`endif

    state_e state_q, state_d;

    logic [15:0]        pitch_q;
    logic signed [15:0] res_q;
    logic [17:0]        y0_q, y1_q, m_q, t_q;
    logic [5:0]         idx, lo;
    logic [3:0]         oct;

    assign idx = pitch_q[11:6];
    assign lo  = pitch_q[5:0];
    assign oct = pitch_q[15:12];

    // 32768 * 2^(k/64), k = 0..64
    function automatic logic [17:0] exp_lut(input logic [6:0] k);
        case (k)
            7'd0:  return 18'd32768; 7'd1:  return 18'd33125; 7'd2:  return 18'd33486;
            7'd3:  return 18'd33850; 7'd4:  return 18'd34219; 7'd5:  return 18'd34591;
            7'd6:  return 18'd34968; 7'd7:  return 18'd35349; 7'd8:  return 18'd35734;
            7'd9:  return 18'd36123; 7'd10: return 18'd36516; 7'd11: return 18'd36914;
            7'd12: return 18'd37316; 7'd13: return 18'd37722; 7'd14: return 18'd38133;
            7'd15: return 18'd38548; 7'd16: return 18'd38968; 7'd17: return 18'd39392;
            7'd18: return 18'd39821; 7'd19: return 18'd40255; 7'd20: return 18'd40693;
            7'd21: return 18'd41136; 7'd22: return 18'd41584; 7'd23: return 18'd42037;
            7'd24: return 18'd42495; 7'd25: return 18'd42958; 7'd26: return 18'd43425;
            7'd27: return 18'd43898; 7'd28: return 18'd44376; 7'd29: return 18'd44859;
            7'd30: return 18'd45348; 7'd31: return 18'd45842; 7'd32: return 18'd46341;
            7'd33: return 18'd46846; 7'd34: return 18'd47356; 7'd35: return 18'd47871;
            7'd36: return 18'd48393; 7'd37: return 18'd48920; 7'd38: return 18'd49452;
            7'd39: return 18'd49991; 7'd40: return 18'd50535; 7'd41: return 18'd51085;
            7'd42: return 18'd51642; 7'd43: return 18'd52204; 7'd44: return 18'd52773;
            7'd45: return 18'd53347; 7'd46: return 18'd53928; 7'd47: return 18'd54515;
            7'd48: return 18'd55109; 7'd49: return 18'd55709; 7'd50: return 18'd56316;
            7'd51: return 18'd56929; 7'd52: return 18'd57549; 7'd53: return 18'd58176;
            7'd54: return 18'd58809; 7'd55: return 18'd59449; 7'd56: return 18'd60097;
            7'd57: return 18'd60751; 7'd58: return 18'd61413; 7'd59: return 18'd62081;
            7'd60: return 18'd62757; 7'd61: return 18'd63441; 7'd62: return 18'd64132;
            7'd63: return 18'd64830; 7'd64: return 18'd65536;
            default: return 18'd65536;
        endcase
    endfunction

    // Single shared multiplier; operands are always non-negative and below 2^17
    logic signed [17:0] mul_a, mul_b;
    logic signed [35:0] prod;
    logic [17:0]        prod_q15, prod_q6;
    logic               unused_prod;

    assign prod        = 36'(mul_a) * 36'(mul_b);
    assign prod_q15    = prod[32:15];
    assign prod_q6     = prod[23:6];
    assign unused_prod = ^{prod[35:33], prod[5:0]};

    // Octave shift at 33 bits so large octaves cannot wrap before saturation
    logic [32:0] shifted;
    logic [17:0] x_sat;
    assign shifted = {15'd0, t_q} << oct;
    assign x_sat   = (shifted > 33'd32767) ? 18'd32767 : shifted[17:0];

    logic        fin;
    logic [15:0] g_d;

`ifdef KARLSEN_COEFF_TAN_WARP_EN
    logic [17:0] x_q, x2_q, x3_q, c_q;
    logic [18:0] sum;
    assign sum = {1'b0, x_q} + {1'b0, c_q};
    assign fin = (state_q == StSum);
    assign g_d = (sum > 19'd32767) ? 16'd32767 : sum[15:0];
`else
    logic [17:0] unused_third;
    assign unused_third = 18'(THIRD);
    assign fin = (state_q == StShift);
    assign g_d = x_sat[15:0];
`endif

    always_comb begin
        mul_a = '0;
        mul_b = '0;
        case (state_q)
            StInterp: begin
                mul_a = y1_q - y0_q;
                mul_b = {12'd0, lo};
            end
            StScale: begin
                mul_a = m_q;
                mul_b = 18'(X0);
            end
`ifdef KARLSEN_COEFF_TAN_WARP_EN
            StSq: begin
                mul_a = x_q;
                mul_b = x_q;
            end
            StCube: begin
                mul_a = x2_q;
                mul_b = x_q;
            end
            StThird: begin
                mul_a = x3_q;
                mul_b = 18'(THIRD);
            end
`endif
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StLut:    state_d = StInterp;
            StInterp: state_d = StScale;
            StScale:  state_d = StShift;
`ifdef KARLSEN_COEFF_TAN_WARP_EN
            StShift:  state_d = StSq;
            StSq:     state_d = StCube;
            StCube:   state_d = StThird;
            StThird:  state_d = StSum;
            StSum:    state_d = StIdle;
`else
            StShift:  state_d = StIdle;
`endif
            default:  state_d = StIdle;
        endcase
        // A strobe always (re)starts; the final state still publishes its result
        if (strobe) state_d = StLut;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            g         <= '0;
            resonance <= '0;
            g_valid   <= 1'b0;
        end else begin
            state_q <= state_d;
            g_valid <= fin;
            if (fin) begin
                g         <= g_d;
                resonance <= res_q[15] ? 16'sd0 : res_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (strobe && !rst) begin
            pitch_q <= pitch;
            res_q   <= resonance_in;
        end
        case (state_q)
            StLut: begin
                y0_q <= exp_lut({1'b0, idx});
                y1_q <= exp_lut({1'b0, idx} + 7'd1);
            end
            StInterp: m_q  <= y0_q + prod_q6;
            StScale:  t_q  <= prod_q15;
`ifdef KARLSEN_COEFF_TAN_WARP_EN
            StShift:  x_q  <= x_sat;
            StSq:     x2_q <= prod_q15;
            StCube:   x3_q <= prod_q15;
            StThird:  c_q  <= prod_q15;
`endif
            default: ;
        endcase
    end

endmodule

// File: tb/tb_karlsen_cutoff_coeff_gen.sv
// Scoreboard bench for karlsen_cutoff_coeff_gen; honours KARLSEN_COEFF_TAN_WARP_EN.
module tb_karlsen_cutoff_coeff_gen;

`ifdef KARLSEN_COEFF_TAN_WARP_EN
    localparam int Lat     = 8;
    localparam int RstEdge = 5;
    localparam int G9000   = 25328;
`else
    localparam int Lat     = 4;
    localparam int RstEdge = 3;
    localparam int G9000   = 22016;
`endif

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               strobe = 1'b0;
    logic [15:0]        pitch = '0;
    logic signed [15:0] resonance_in = '0;
    logic signed [15:0] g, resonance;
    logic               g_valid;

    karlsen_cutoff_coeff_gen dut (
        .clk          (clk),
        .rst          (rst),
        .strobe       (strobe),
        .pitch        (pitch),
        .resonance_in (resonance_in),
        .g            (g),
        .resonance    (resonance),
        .g_valid      (g_valid)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int g;
        int r;
        int cyc;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   hold_g = 0;
    int   hold_r = 0;
    bit   hold_en = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops one expectation per g_valid pulse, otherwise checks g/resonance hold
    always @(negedge clk) begin
        if (g_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_g_valid", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("valid_cycle", cyc, e.cyc);
                check("g", int'(g), e.g);
                check("resonance", int'(resonance), e.r);
                hold_g = e.g;
                hold_r = e.r;
            end
        end else if (hold_en) begin
            check("g_hold", int'(g), hold_g);
            check("resonance_hold", int'(resonance), hold_r);
        end
    end

    // Called at posedge+#1; strobe is sampled on the next edge (E0)
    task automatic issue(input logic [15:0] p, input int r, input bit push,
                         input int eg, input int er);
        exp_t e;
        strobe       = 1'b1;
        pitch        = p;
        resonance_in = 16'(r);
        if (push) begin
            e.g   = eg;
            e.r   = er;
            e.cyc = cyc + 1 + Lat;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        strobe = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 40) begin
            @(posedge clk);
            n++;
        end
        check({"drain_", name}, sb.size(), 0);
        sb.delete();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset_g", int'(g), 0);
        check("reset_resonance", int'(resonance), 0);
        check("reset_g_valid", int'(g_valid), 0);
        hold_en = 1'b1;

        issue(16'h0000, 1000, 1, 43, 1000);
        wait_drain("pitch0");
        issue(16'h0800, 2000, 1, 60, 2000);
        wait_drain("pitch0800");
        issue(16'h9000, 300, 1, G9000, 300);
        wait_drain("pitch9000");
        issue(16'hF000, -500, 1, 32767, 0);
        wait_drain("pitchF000");

        // Restart at E3: the first run must never report
        issue(16'h9000, 7, 0, 0, 0);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        issue(16'h0000, 9, 1, 43, 9);
        wait_drain("restart");

        // Reset mid-run
        issue(16'h9000, 5, 0, 0, 0);
        repeat (RstEdge - 1) begin
            @(posedge clk);
            #1;
        end
        hold_en = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("midrun_reset_g", int'(g), 0);
        check("midrun_reset_resonance", int'(resonance), 0);
        check("midrun_reset_g_valid", int'(g_valid), 0);
        hold_g  = 0;
        hold_r  = 0;
        hold_en = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        issue(16'h5000, -1, 1, 1376, 0);
        wait_drain("after_reset");

        // Strobe coinciding with the final state: both runs report
        issue(16'h0800, 11, 1, 60, 11);
        repeat (Lat - 1) begin
            @(posedge clk);
            #1;
        end
        issue(16'h0000, 12, 1, 43, 12);
        wait_drain("back_to_back");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
